// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-order pipeline hazard detector for a 3-bit register file.
// It tracks the destination registers of the last three issued instructions
// (EX, MEM, WB) and stalls decode while a source operand depends on one of them.
// Build option: define HAZARD_FORWARD_EN when the datapath forwards results.
//   defined   -> stall only on load-use (dependency on a load sitting in EX)
//   undefined -> stall on any dependency in EX, MEM or WB (no RF write-through)
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic       id_rs_used,
  input  logic [2:0] id_rt,
  input  logic       id_rt_used,
  input  logic       id_writes,
  input  logic [2:0] id_rd,
  input  logic       id_is_load,
  input  logic       flush,
  output logic       stall,
  output logic [7:0] stall_cycles
);

  // One tracker slot: a pending register write of an in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       is_load;
  } entry_t;

  localparam int unsigned NSTAGE = 3;
  localparam int unsigned EX     = 0;
  localparam int unsigned MEM    = 1;
  localparam int unsigned WB     = 2;

  localparam entry_t     ENTRY_NONE = '{valid: 1'b0, rd: 3'd0, is_load: 1'b0};
  localparam logic [7:0] CNT_MAX    = 8'd255;

  entry_t     trk_q [NSTAGE];
  entry_t     trk_d [NSTAGE];
  logic [7:0] stall_cycles_q;
  logic [7:0] stall_cycles_d;

  logic       hit_s [NSTAGE];
  logic       hazard_s;
  logic       issue_s;

  // A used source operand equals the pending destination of a valid entry.
  // R0 is an ordinary register here, so it is deliberately not excluded.
  function automatic logic src_match(input entry_t     e,
                                     input logic [2:0] rs,
                                     input logic       rs_used,
                                     input logic [2:0] rt,
                                     input logic       rt_used);
    logic rs_hit;
    logic rt_hit;
    rs_hit = rs_used & (rs == e.rd);
    rt_hit = rt_used & (rt == e.rd);
    return e.valid & (rs_hit | rt_hit);
  endfunction

  // Six comparisons per cycle: both sources against every tracker stage.
  always_comb begin
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      hit_s[i] = src_match(trk_q[i], id_rs, id_rs_used, id_rt, id_rt_used);
    end
  end

  // Select which matches actually require a stall for this datapath flavour.
  always_comb begin
`ifdef HAZARD_FORWARD_EN
    // Forwarding covers everything except a load whose data is not ready yet.
    hazard_s = hit_s[EX] & trk_q[EX].is_load;
`else
    // Without forwarding, decode must wait until the writer has left WB.
    hazard_s = hit_s[EX] | hit_s[MEM] | hit_s[WB];
`endif
  end

  // Stall only a real instruction that is not being squashed this cycle.
  always_comb begin
    if (id_valid && !flush) begin
      stall = hazard_s;
    end else begin
      stall = 1'b0;
    end
  end

  // The decode instruction enters EX only when it writes and is neither held nor squashed.
  always_comb begin
    issue_s = id_valid & id_writes & ~stall & ~flush;
  end

  // Tracker next state: shift unconditionally; flush kills the EX and MEM slots.
  always_comb begin
    if (issue_s) begin
      trk_d[EX] = '{valid: 1'b1, rd: id_rd, is_load: id_is_load};
    end else begin
      trk_d[EX] = ENTRY_NONE;
    end
    if (flush) begin
      trk_d[MEM] = ENTRY_NONE;
    end else begin
      trk_d[MEM] = trk_q[EX];
    end
    trk_d[WB] = trk_q[MEM];
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    if (stall && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 8'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Tracker registers; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        trk_q[i] <= ENTRY_NONE;
      end
    end else begin
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 8'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, compared against a queue-based model of the in-flight writers.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_used;
  logic [2:0] id_rt;
  logic       id_rt_used;
  logic       id_writes;
  logic [2:0] id_rd;
  logic       id_is_load;
  logic       flush;
  logic       stall;
  logic [7:0] stall_cycles;

  hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rt        (id_rt),
    .id_rt_used   (id_rt_used),
    .id_writes    (id_writes),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: list of in-flight writers, youngest first (index 0 = EX).
  typedef struct {
    bit       v;
    bit [2:0] r;
    bit       ld;
  } ent_t;

  ent_t mq[$];
  int   mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input bit [2:0] r);
    return (id_rs_used && id_rs == r) || (id_rt_used && id_rt == r);
  endfunction

  // Decode must wait if it reads a register some older instruction has not
  // yet made available.
  function automatic bit model_stall();
    if (!id_valid || flush) return 1'b0;
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].v && reads(mq[k].r)) begin
        if (!FWD) return 1'b1;
        if (k == 0 && mq[k].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    ent_t bub;
    bub = '{v: 1'b0, r: 3'd0, ld: 1'b0};
    mq = '{bub, bub, bub};
    mcnt = 0;
  endtask

  task automatic drive(input bit v, input bit [2:0] rs, input bit rsu,
                       input bit [2:0] rt, input bit rtu, input bit wr,
                       input bit [2:0] rd, input bit ld, input bit fl);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_writes = wr; id_rd = rd; id_is_load = ld; flush = fl;
    #1;
  endtask

  // Check outputs against the model, then clock one edge and advance the model.
  task automatic tick(input string tag);
    bit   ms;
    ent_t nx;
    ent_t bub;
    ent_t old0;
    ent_t old1;
    ms = model_stall();
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, ms});
    chk({tag, "_cnt"}, {24'd0, stall_cycles}, mcnt);
    bub = '{v: 1'b0, r: 3'd0, ld: 1'b0};
    nx = (id_valid && id_writes && !ms && !flush) ? '{v: 1'b1, r: id_rd, ld: id_is_load} : bub;
    old0 = mq[0];
    old1 = mq[1];
    @(posedge clk);
    mq = '{nx, (flush ? bub : old0), old1};
    if (ms && mcnt < 255) mcnt++;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick("idle");
  endtask

  // Count consecutive stall cycles with decode held; bounded wait.
  task automatic measure(input string tag, output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (!stall) break;
      n++;
      tick(tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_rst_cnt"}, {24'd0, stall_cycles}, 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  int  n;
  int  base;
  bit  hold;

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    model_reset();
    pulse_reset("init");

    // ADD writes R3, next decode reads R3 through rs.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    tick("add_r3");
    drive(1'b1, 3'd3, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    measure("raw_r3", n);
    chk("raw_r3_len", n, FWD ? 32'd0 : 32'd3);
    chk("raw_r3_total", {24'd0, stall_cycles}, FWD ? 32'd0 : 32'd3);
    tick("raw_r3_go");
    idle(3);

    // Load writes R5, next decode reads R5 through rt.
    base = mcnt;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    tick("ld_r5");
    drive(1'b1, 3'd1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    measure("lduse", n);
    chk("lduse_len", n, FWD ? 32'd1 : 32'd3);
    chk("lduse_total", {24'd0, stall_cycles} - base, FWD ? 32'd1 : 32'd3);
    tick("lduse_go");
    idle(3);

    // Same dependency from a non-load writer.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    tick("alu_r5");
    drive(1'b1, 3'd1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    measure("alu_use", n);
    chk("alu_use_len", n, FWD ? 32'd0 : 32'd3);
    tick("alu_use_go");
    idle(3);

    // Unused source register matching a pending write must not stall.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    tick("wr_r2");
    drive(1'b1, 3'd2, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("unused_src", {31'd0, stall}, 32'd0);
    tick("unused_src");
    idle(3);

    // R0 is an ordinary register.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    tick("wr_r0");
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("r0_dep", {31'd0, stall}, 32'd1);
    measure("r0_dep", n);
    tick("r0_go");
    idle(3);

    // Flush squashes a pending writer in the same cycle as a matching decode.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    tick("wr_r6");
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("flush_same", {31'd0, stall}, 32'd0);
    tick("flush");
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("flush_after", {31'd0, stall}, 32'd0);
    tick("flush_after");
    idle(3);

    // Reset in the middle of a stall discards the writer.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    tick("wr_r6b");
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    pulse_reset("midstall");
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("post_rst_r6", {31'd0, stall}, 32'd0);
    tick("post_rst");
    idle(3);

    // Long dependent chain of loads on R1 drives the counter into saturation.
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    for (int k = 0; k < 700; k++) tick("chain");
    chk("sat_255", {24'd0, stall_cycles}, 32'd255);
    idle(3);

    // Randomized traffic; decode is held while stalled, resets are rare.
    pulse_reset("rand_start");
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 500; k++) begin
      hold = model_stall();
      if (!hold) begin
        drive(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 1'($urandom),
              3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
              3'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 11) == 0));
      end else begin
        flush = ($urandom_range(0, 11) == 0);
        #1;
      end
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rand_rst");
        #1;
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these data ports: id_valid  in  1  decode slot holds a real instruction.
REQ-003 The block SHALL have: id_rs  in  3  source register A; id_rs_used  in  1  source A is read.
REQ-004 The block SHALL have: id_rt  in  3  source register B; id_rt_used  in  1  source B is read.
REQ-005 The block SHALL have: id_writes  in  1  decode instruction writes a register; id_rd  in  3  destination register; id_is_load  in  1  decode instruction is a load.
REQ-006 The block SHALL have: flush  in  1  squash decode and EX (taken branch or jump).
REQ-007 The block SHALL have: stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-008 The block SHALL have: stall_cycles  out  8  saturating count of stalled cycles.

Function
REQ-009 The block SHALL hold a 3-stage tracker (EX, MEM, WB); each entry SHALL be {valid, reg[2:0], is_load}.
REQ-010 Every cycle, the block SHALL advance the tracker unconditionally: WB <= MEM and MEM <= EX.
REQ-011 EX SHALL load {1, id_rd, id_is_load} when id_valid & id_writes & ~stall & ~flush; otherwise EX SHALL load a bubble (valid=0).
REQ-012 On flush, the next EX and MEM entries SHALL be invalid; WB SHALL still take the old MEM entry.
REQ-013 A match SHALL be a 3-bit equality between a used source (rs with rs_used, rt with rt_used) and a valid tracker reg; the block SHALL perform 6 comparisons per cycle.
REQ-014 R0 SHALL be treated as an ordinary register, with no special-case exclusion.
REQ-015 stall SHALL be combinational from the inputs and current tracker state, and SHALL be forced to 0 when id_valid=0 or flush=1.
REQ-016 While stall=1, the decode inputs SHALL be held by the upstream stages; the block SHALL re-evaluate every cycle until no match remains.
REQ-017 A dependency SHALL produce a bounded stall: at most 3 cycles without forwarding, and at most 1 cycle with forwarding.
REQ-018 stall_cycles SHALL increment by 1 on each cycle with stall=1 and SHALL saturate at 255.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately clear all tracker valid bits to 0 and stall_cycles to 0; stall SHALL therefore read 0.
REQ-020 Reset asserted mid-stall SHALL discard all in-flight entries, and no stale match SHALL survive.
REQ-021 The first rising edge after rst_n deasserts SHALL operate normally.

Configuration
REQ-022 The macro HAZARD_FORWARD_EN SHALL select the stall rule.
REQ-023 When HAZARD_FORWARD_EN is defined, stall SHALL be asserted only on a match against the EX entry with is_load=1 (load-use); MEM and WB matches SHALL be ignored.
REQ-024 When HAZARD_FORWARD_EN is undefined, stall SHALL be asserted on a match against any valid EX, MEM or WB entry (the register file has no write-through bypass).

Verification
REQ-025 Scenario, no forwarding: ADD writes R3; next decode reads rs=R3 -> stall=1 for 3 consecutive cycles, then 0; stall_cycles=3.
REQ-026 Scenario, HAZARD_FORWARD_EN defined: load writes R5; next decode reads rt=R5 -> stall=1 for exactly 1 cycle. Repeating this with a non-load writer -> stall=0.
REQ-027 Scenario: write R2 in EX; decode has rs=R2 with rs_used=0, and rt=R4 -> stall=0.
REQ-028 Scenario: match pending on R6 and flush=1 in the same cycle -> stall=0; the next cycle shows EX and MEM invalid and no stall from the squashed writer.
REQ-029 Scenario: rst_n pulsed low during a 3-cycle stall -> stall=0 and stall_cycles=0 immediately; a decode reading R6 after release -> stall=0.
REQ-030 Scenario: 300 consecutive stall cycles, each re-triggered by a dependent chain -> stall_cycles holds at 255.
